// File: rtl/execute_stage_if.sv
// execute_stage_if: ID/EX inputs, MEM back-pressure and EX/MEM outputs of the execute stage.
// Handshake: ID/EX is accepted on a rising edge where PIP_valid_i=1 and ex_busy_o=0; while ex_busy_o=1 every PIP_*_i is held stable.
interface execute_stage_if #(parameter int XLEN = 32);
   logic            PIP_valid_i;
   logic [XLEN-1:0] PIP_operand1_i;
   logic [XLEN-1:0] PIP_operand2_i;
   logic [XLEN-1:0] PIP_immediate_i;
   logic            PIP_use_imm_i;
   logic [4:0]      PIP_aluOper_i;
   logic [4:0]      PIP_rd_i;
   logic            PIP_write_mem_i;
   logic            PIP_read_mem_i;
   logic            PIP_use_mem_i;
   logic            PIP_write_reg_i;
   logic            stall_i;
   logic            flush_i;
   logic            ex_busy_o;
   logic            PIP_valid_o;
   logic [XLEN-1:0] PIP_alu_result_o;
   logic [XLEN-1:0] PIP_second_operand_o;
   logic            PIP_write_mem_o;
   logic            PIP_read_mem_o;
   logic            PIP_use_mem_o;
   logic            PIP_write_reg_o;
   logic [4:0]      PIP_rd_o;

   modport master (
      output PIP_valid_i, PIP_operand1_i, PIP_operand2_i, PIP_immediate_i, PIP_use_imm_i,
             PIP_aluOper_i, PIP_rd_i, PIP_write_mem_i, PIP_read_mem_i, PIP_use_mem_i,
             PIP_write_reg_i, stall_i, flush_i,
      input  ex_busy_o, PIP_valid_o, PIP_alu_result_o, PIP_second_operand_o, PIP_write_mem_o,
             PIP_read_mem_o, PIP_use_mem_o, PIP_write_reg_o, PIP_rd_o
   );

   modport slave (
      input  PIP_valid_i, PIP_operand1_i, PIP_operand2_i, PIP_immediate_i, PIP_use_imm_i,
             PIP_aluOper_i, PIP_rd_i, PIP_write_mem_i, PIP_read_mem_i, PIP_use_mem_i,
             PIP_write_reg_i, stall_i, flush_i,
      output ex_busy_o, PIP_valid_o, PIP_alu_result_o, PIP_second_operand_o, PIP_write_mem_o,
             PIP_read_mem_o, PIP_use_mem_o, PIP_write_reg_o, PIP_rd_o
   );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: RV EX stage -- base ALU, single-cycle multiply, iterative radix-2 divider,
// and the EX/MEM pipeline register with stall hold and flush.
module execute_stage #(
   parameter int XLEN      = 32,
   parameter bit MULDIV_EN = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   execute_stage_if.slave ex_io,
   output logic [1:0]     dbg_state_o
);
   localparam int SHW = $clog2(XLEN);
   localparam int CW  = $clog2(XLEN + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} div_state_e;

   logic [XLEN-1:0] op_a, op_b;
   logic [4:0]      op;
   logic [SHW-1:0]  shamt;

   assign op_a  = ex_io.PIP_operand1_i;
   assign op_b  = ex_io.PIP_use_imm_i ? ex_io.PIP_immediate_i : ex_io.PIP_operand2_i;
   assign op    = ex_io.PIP_aluOper_i;
   assign shamt = op_b[SHW-1:0];

   logic is_div_op, is_sdiv, div_start;
   div_state_e state_q;

   assign is_div_op = MULDIV_EN && (op >= 5'd13) && (op <= 5'd16);
   assign is_sdiv   = (op == 5'd13) || (op == 5'd15);
   assign div_start = (state_q == S_IDLE) && ex_io.PIP_valid_i && is_div_op && !ex_io.flush_i;

   // One multiplier serves MUL/MULH/MULHU: operands are sign-extended only for MULH.
   logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
   assign mul_a = {{XLEN{op_a[XLEN-1] & (op == 5'd11)}}, op_a};
   assign mul_b = {{XLEN{op_b[XLEN-1] & (op == 5'd11)}}, op_b};
   assign mul_p = mul_a * mul_b;

   logic [CW-1:0]   count_q;
   logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
   logic            q_neg_q, r_neg_q, dz_q;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN:0]   shifted, diff;

   assign a_mag   = (is_sdiv && op_a[XLEN-1]) ? -op_a : op_a;
   assign b_mag   = (is_sdiv && op_b[XLEN-1]) ? -op_b : op_b;
   assign shifted = {rem_q, quo_q[XLEN-1]};
   assign diff    = shifted - {1'b0, dvsr_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dz_q    <= 1'b0;
      end else if (ex_io.flush_i) begin
         state_q <= S_IDLE;
         count_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (div_start) begin
               state_q <= S_DIV;
               count_q <= CW'(XLEN);
               rem_q   <= '0;
               quo_q   <= a_mag;
               dvsr_q  <= b_mag;
               q_neg_q <= is_sdiv && (op_a[XLEN-1] ^ op_b[XLEN-1]);
               r_neg_q <= is_sdiv && op_a[XLEN-1];
               dz_q    <= (op_b == '0);
            end
            S_DIV: begin
               rem_q   <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
               quo_q   <= {quo_q[XLEN-2:0], ~diff[XLEN]};
               count_q <= count_q - CW'(1);
               if (count_q == CW'(1)) state_q <= S_DONE;
            end
            S_DONE: if (!ex_io.stall_i) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dbg_state_o     = state_q;
   assign ex_io.ex_busy_o = ex_io.stall_i || div_start || (state_q == S_DIV);

   // Divide-by-zero leaves quo=all-ones magnitude and rem=|A|, so only the quotient sign needs masking.
   logic [XLEN-1:0] q_res, r_res, alu_res;
   assign q_res = dz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
   assign r_res = r_neg_q ? -rem_q : rem_q;

   always_comb begin
      alu_res = '0;
      case (op)
         5'd0:  alu_res = op_a + op_b;
         5'd1:  alu_res = op_a - op_b;
         5'd2:  alu_res = op_a & op_b;
         5'd3:  alu_res = op_a ^ op_b;
         5'd4:  alu_res = op_a | op_b;
         5'd5:  alu_res = op_a << shamt;
         5'd6:  alu_res = op_a >> shamt;
         5'd7:  alu_res = $signed(op_a) >>> shamt;
         5'd8:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         5'd9:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         5'd10: alu_res = MULDIV_EN ? mul_p[XLEN-1:0] : '0;
         5'd11, 5'd12: alu_res = MULDIV_EN ? mul_p[2*XLEN-1:XLEN] : '0;
         5'd13, 5'd14: alu_res = MULDIV_EN ? q_res : '0;
         5'd15, 5'd16: alu_res = MULDIV_EN ? r_res : '0;
         default: alu_res = '0;
      endcase
   end

   logic bubble;
   assign bubble = !ex_io.PIP_valid_i || (is_div_op && (state_q != S_DONE));

   logic            valid_q, wm_q, rm_q, um_q, wr_q;
   logic [XLEN-1:0] res_q, sop_q;
   logic [4:0]      rd_q;

   always_ff @(posedge clk) begin
      if (reset || (!ex_io.stall_i && (ex_io.flush_i || bubble))) begin
         valid_q <= 1'b0;
         res_q   <= '0;
         sop_q   <= '0;
         rd_q    <= '0;
         wm_q    <= 1'b0;
         rm_q    <= 1'b0;
         um_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else if (!ex_io.stall_i) begin
         valid_q <= 1'b1;
         res_q   <= alu_res;
         sop_q   <= ex_io.PIP_operand2_i;
         rd_q    <= ex_io.PIP_rd_i;
         wm_q    <= ex_io.PIP_write_mem_i;
         rm_q    <= ex_io.PIP_read_mem_i;
         um_q    <= ex_io.PIP_use_mem_i;
         wr_q    <= ex_io.PIP_write_reg_i;
      end
   end

   assign ex_io.PIP_valid_o          = valid_q;
   assign ex_io.PIP_alu_result_o     = res_q;
   assign ex_io.PIP_second_operand_o = sop_q;
   assign ex_io.PIP_rd_o             = rd_q;
   assign ex_io.PIP_write_mem_o      = wm_q;
   assign ex_io.PIP_read_mem_o       = rm_q;
   assign ex_io.PIP_use_mem_o        = um_q;
   assign ex_io.PIP_write_reg_o      = wr_q;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and randomized checks of execute_stage against an arithmetic reference model.
module tb_execute_stage;
   localparam int XLEN = 32;
   localparam int W    = 73;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   execute_stage_if #(.XLEN(XLEN)) ex_io();

   execute_stage #(.XLEN(XLEN), .MULDIV_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .ex_io(ex_io), .dbg_state_o(dbg_state)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [3:0] ctl_o();
      return {ex_io.PIP_write_mem_o, ex_io.PIP_read_mem_o, ex_io.PIP_use_mem_o, ex_io.PIP_write_reg_o};
   endfunction

   // Reference: RV semantics in 64-bit arithmetic, truncated to XLEN.
   function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     res;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      res = '0;
      case (op)
         5'd0:  res = ua + ub;
         5'd1:  res = ua - ub;
         5'd2:  res = ua & ub;
         5'd3:  res = ua ^ ub;
         5'd4:  res = ua | ub;
         5'd5:  res = ua << b[4:0];
         5'd6:  res = ua >> b[4:0];
         5'd7:  res = sa >>> b[4:0];
         5'd8:  res = (sa < sb) ? 64'd1 : 64'd0;
         5'd9:  res = (ua < ub) ? 64'd1 : 64'd0;
         5'd10: res = sa * sb;
         5'd11: res = (sa * sb) >>> 32;
         5'd12: res = (ua * ub) >> 32;
         5'd13: if (b == 0) res = 64'hFFFF_FFFF; else res = sa / sb;
         5'd14: if (b == 0) res = 64'hFFFF_FFFF; else res = ua / ub;
         5'd15: if (b == 0) res = ua; else res = sa % sb;
         5'd16: if (b == 0) res = ua; else res = ua % ub;
         default: res = '0;
      endcase
      return res[31:0];
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   task automatic set_inputs(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic ui, input logic [4:0] rd, input logic [3:0] ctl);
      ex_io.PIP_valid_i     = v;
      ex_io.PIP_aluOper_i   = op;
      ex_io.PIP_operand1_i  = a;
      ex_io.PIP_operand2_i  = b;
      ex_io.PIP_immediate_i = imm;
      ex_io.PIP_use_imm_i   = ui;
      ex_io.PIP_rd_i        = rd;
      {ex_io.PIP_write_mem_i, ex_io.PIP_read_mem_i, ex_io.PIP_use_mem_i, ex_io.PIP_write_reg_i} = ctl;
   endtask

   // Present one instruction, hold it while busy, then check latency, busy length and EX/MEM contents.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic ui, input logic [4:0] rd, input logic [3:0] ctl, input string tag);
      logic [31:0]  bsel;
      logic [W-1:0] exp;
      bit           is_div, got;
      int           cycles, busy_cnt, bad_bubbles;
      bsel = ui ? imm : b;
      is_div = (op >= 13) && (op <= 16);
      got = 0; cycles = 0; busy_cnt = 0; bad_bubbles = 0;
      set_inputs(1'b1, op, a, b, imm, ui, rd, ctl);
      exp_q.push_back({ref_alu(op, a, bsel), b, rd, ctl});
      while (!got && cycles < 100) begin
         #1;
         if (ex_io.ex_busy_o) busy_cnt++;
         @(posedge clk); #1;
         cycles++;
         if (ex_io.PIP_valid_o) got = 1;
         else if (ex_io.PIP_alu_result_o != 0 || ex_io.PIP_second_operand_o != 0 ||
                  ex_io.PIP_rd_o != 0 || ctl_o() != 0) bad_bubbles++;
      end
      ex_io.PIP_valid_i = 1'b0;
      check({tag, ":latency"}, 64'(cycles), is_div ? 64'(XLEN + 2) : 64'd1);
      check({tag, ":busy_cycles"}, 64'(busy_cnt), is_div ? 64'(XLEN + 1) : 64'd0);
      check({tag, ":bubbles_zero"}, 64'(bad_bubbles), 64'd0);
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         if (got) begin
            check({tag, ":result"}, 64'(ex_io.PIP_alu_result_o), 64'(exp[72:41]));
            check({tag, ":second_op"}, 64'(ex_io.PIP_second_operand_o), 64'(exp[40:9]));
            check({tag, ":rd_ctl"}, 64'({ex_io.PIP_rd_o, ctl_o()}), 64'(exp[8:0]));
         end
      end
   endtask

   task automatic idle_cycle();
      ex_io.PIP_valid_i   = 1'b0;
      ex_io.PIP_aluOper_i = 5'd13;
      #1;
      check("idle:busy", 64'(ex_io.ex_busy_o), 64'd0);
      @(posedge clk); #1;
      check("idle:valid_o", 64'(ex_io.PIP_valid_o), 64'd0);
      check("idle:ctl_o", 64'(ctl_o()), 64'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          pulses, pulse_cycle, held_bad;
      logic        busy_now;
      logic [31:0] res_seen;
      logic [72:0] snap, now_o;
      logic [1:0]  st11;

      // ---- clock/reset ----
      reset = 1'b1;
      set_inputs(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'd0);
      ex_io.stall_i = 1'b0;
      ex_io.flush_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset:valid_o", 64'(ex_io.PIP_valid_o), 64'd0);
      check("reset:result", 64'(ex_io.PIP_alu_result_o), 64'd0);
      check("reset:second_op", 64'(ex_io.PIP_second_operand_o), 64'd0);
      check("reset:rd_ctl", 64'({ex_io.PIP_rd_o, ctl_o()}), 64'd0);
      check("reset:busy", 64'(ex_io.ex_busy_o), 64'd0);
      check("reset:state", 64'(dbg_state), 64'd0);

      // ---- directed ----
      issue(5'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd1, 4'b0001, "add");
      issue(5'd1, 32'd3, 32'd5, 32'd0, 1'b0, 5'd2, 4'b0001, "sub");
      issue(5'd7, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd3, 4'b0001, "sra");
      issue(5'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd4, 4'b0001, "sltu");
      issue(5'd0, 32'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 1'b1, 5'd0, 4'b1010, "addi_store");
      issue(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd5, 4'b0001, "mulh");
      issue(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd6, 4'b0001, "mulhu");
      issue(5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd7, 4'b0001, "mul");
      issue(5'd13, -32'sd7, 32'd2, 32'd0, 1'b0, 5'd8, 4'b0001, "div_neg");
      issue(5'd15, -32'sd7, 32'd2, 32'd0, 1'b0, 5'd8, 4'b0001, "rem_neg");
      issue(5'd14, 32'd7, 32'd0, 32'd0, 1'b0, 5'd8, 4'b0001, "divu_zero");
      issue(5'd15, 32'd7, 32'd0, 32'd0, 1'b0, 5'd8, 4'b0001, "rem_zero");
      issue(5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd8, 4'b0001, "div_ovf");
      issue(5'd20, 32'd9, 32'd9, 32'd0, 1'b0, 5'd8, 4'b0001, "op_unused");

      // ---- stall while dividing: DIVU 100/7, stall in cycles 20..40 ----
      idle_cycle();
      set_inputs(1'b1, 5'd14, 32'd100, 32'd7, 32'd0, 1'b0, 5'd9, 4'b0001);
      pulses = 0; pulse_cycle = -1; held_bad = 0; res_seen = '0; snap = '0;
      for (int c = 0; c < 60; c++) begin
         ex_io.stall_i = (c >= 20 && c <= 40);
         #1;
         busy_now = ex_io.ex_busy_o;
         now_o = {ex_io.PIP_valid_o, ex_io.PIP_alu_result_o, ex_io.PIP_second_operand_o, ex_io.PIP_rd_o, ctl_o()};
         if (ex_io.PIP_valid_o) begin
            pulses++;
            pulse_cycle = c;
            res_seen = ex_io.PIP_alu_result_o;
         end
         if (c == 20) snap = now_o;
         if (c > 20 && c <= 41 && now_o != snap) held_bad++;
         @(posedge clk); #1;
         if (!busy_now) ex_io.PIP_valid_i = 1'b0;
      end
      ex_io.stall_i = 1'b0;
      check("stall:pulses", 64'(pulses), 64'd1);
      check("stall:pulse_cycle", 64'(pulse_cycle), 64'd42);
      check("stall:result", 64'(res_seen), 64'd14);
      check("stall:hold", 64'(held_bad), 64'd0);

      // ---- flush at cycle 10 of a divide, ADD 1+1 next cycle ----
      idle_cycle();
      set_inputs(1'b1, 5'd13, -32'sd7, 32'd2, 32'd0, 1'b0, 5'd11, 4'b0001);
      pulses = 0; st11 = 2'd3;
      for (int c = 0; c < 12; c++) begin
         if (c == 10) ex_io.flush_i = 1'b1;
         if (c == 11) begin
            ex_io.flush_i = 1'b0;
            set_inputs(1'b1, 5'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd12, 4'b0001);
         end
         #1;
         if (c == 11) st11 = dbg_state;
         if (ex_io.PIP_valid_o) pulses++;
         @(posedge clk); #1;
      end
      ex_io.PIP_valid_i = 1'b0;
      check("flush:no_div_result", 64'(pulses), 64'd0);
      check("flush:state_idle", 64'(st11), 64'd0);
      check("flush:add_valid", 64'(ex_io.PIP_valid_o), 64'd1);
      check("flush:add_result", 64'(ex_io.PIP_alu_result_o), 64'd2);
      idle_cycle();

      // ---- reset at cycle 10 of a divide ----
      set_inputs(1'b1, 5'd16, 32'd1000, 32'd3, 32'd0, 1'b0, 5'd13, 4'b0001);
      for (int c = 0; c < 11; c++) begin
         if (c == 10) begin
            reset = 1'b1;
            ex_io.PIP_valid_i = 1'b0;
         end
         @(posedge clk); #1;
      end
      reset = 1'b0;
      check("rst_mid:valid_o", 64'(ex_io.PIP_valid_o), 64'd0);
      check("rst_mid:outputs", 64'({ex_io.PIP_alu_result_o, ex_io.PIP_rd_o, ctl_o()}), 64'd0);
      check("rst_mid:state", 64'(dbg_state), 64'd0);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (ex_io.PIP_valid_o) pulses++;
      end
      check("rst_mid:no_result", 64'(pulses), 64'd0);

      // ---- randomized, back-to-back with occasional bubbles ----
      for (int i = 0; i < 160; i++) begin
         logic [4:0]  rop;
         logic [31:0] ra, rb, rimm;
         rop = 5'($urandom_range(0, 31));
         if (rop >= 13 && rop <= 16 && $urandom_range(0, 3) != 0) rop = rop - 5'd13;
         else if (rop > 16 && $urandom_range(0, 1) == 0) rop = rop - 5'd17;
         ra = pick_val();
         rb = pick_val();
         rimm = pick_val();
         issue(rop, ra, rb, rimm, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               4'($urandom_range(0, 15)), "rand");
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end

      check("scoreboard:empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
